// File: rtl/ram_banked_nxm_if.sv
// Bus bundle for ram_banked_nxm: access request, zero-fill start,
// registered read data and status strobes.
interface ram_banked_nxm_if #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 3
);
  localparam int LANES = DATA_W / LANE_W;

  logic              CS;
  logic              R_W;
  logic [ADDR_W-1:0] ADDR;
  logic [LANES-1:0]  LANE_EN;
  logic [DATA_W-1:0] DATA_IN;
  logic              ZERO;
  logic [DATA_W-1:0] DATA_OUT;
  logic              RD_VALID;
  logic              ADDR_ERR;
  logic              BUSY;

  modport master (
    output CS, R_W, ADDR, LANE_EN, DATA_IN, ZERO,
    input  DATA_OUT, RD_VALID, ADDR_ERR, BUSY
  );

  modport slave (
    input  CS, R_W, ADDR, LANE_EN, DATA_IN, ZERO,
    output DATA_OUT, RD_VALID, ADDR_ERR, BUSY
  );
endinterface

// File: rtl/ram_banked_nxm.sv
// Single-port RAM with per-lane write enables, registered read,
// out-of-range detection and a sequential zero-fill sweep.
module ram_banked_nxm #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic          CLK,
  input  logic          CLR,
  ram_banked_nxm_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_rd_valid;
  logic              r_addr_err;

  logic w_last;
  logic w_in_range;
  logic w_busy;
  logic w_wr;
  logic w_rd;
  logic w_err;

  assign w_last     = (r_cnt == LAST);
  assign w_in_range = (32'(bus.ADDR) < DEPTH_U);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (bus.ZERO) w_next = SWEEP;
      SWEEP: if (w_last)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ZERO wins over a same-cycle access; the sweep blocks all accesses.
  always_comb begin
    w_busy = 1'b0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_err  = 1'b0;
    if (r_state == SWEEP) begin
      w_busy = 1'b1;
    end else if (bus.CS && !bus.ZERO) begin
      if (!w_in_range) w_err = 1'b1;
      else if (bus.R_W) w_wr = 1'b1;
      else w_rd = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (r_state == SWEEP) begin
      r_cnt <= w_last ? '0 : r_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < LANES; i++)
        if (bus.LANE_EN[i])
          r_mem[bus.ADDR][i*LANE_W +: LANE_W] <=
            bus.DATA_IN[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_addr_err <= w_err;
      if (w_rd) r_dout <= r_mem[bus.ADDR];
    end
  end

  assign bus.DATA_OUT = r_dout;
  assign bus.RD_VALID = r_rd_valid;
  assign bus.ADDR_ERR = r_addr_err;
  assign bus.BUSY     = w_busy;
endmodule

// File: tb/tb_ram_banked_nxm.sv
// Table-driven bench for ram_banked_nxm: DEPTH=8 and DEPTH=6 instances
// share clock and reset; expected outputs flow through a scoreboard queue.
module tb_ram_banked_nxm;
  logic CLK = 1'b0;
  logic CLR = 1'b1;

  always #5 CLK = ~CLK;

  ram_banked_nxm_if #(.DATA_W(8), .LANE_W(4), .ADDR_W(3)) bus8 ();
  ram_banked_nxm_if #(.DATA_W(8), .LANE_W(4), .ADDR_W(3)) bus6 ();

  ram_banked_nxm #(.DATA_W(8), .LANE_W(4), .DEPTH(8), .ADDR_W(3)) dut8 (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus8.slave)
  );

  ram_banked_nxm #(.DATA_W(8), .LANE_W(4), .DEPTH(6), .ADDR_W(3)) dut6 (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus6.slave)
  );

  typedef struct {
    bit         s;
    bit         cs;
    bit         rw;
    logic [2:0] a;
    logic [1:0] ln;
    logic [7:0] d;
    bit         z;
    bit         ev;
    bit         ee;
    logic [7:0] ed;
    bit         eb;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(bit s, bit cs, bit rw, int a,
                              logic [1:0] ln, logic [7:0] d, bit z,
                              bit ev, bit ee, logic [7:0] ed, bit eb,
                              string nm);
    vec_t v;
    v.s = s; v.cs = cs; v.rw = rw; v.a = 3'(a); v.ln = ln;
    v.d = d; v.z = z; v.ev = ev; v.ee = ee; v.ed = ed;
    v.eb = eb; v.nm = nm;
    return v;
  endfunction

  function automatic vec_t rd(bit s, int a, logic [7:0] ed);
    return mk(s, 1, 0, a, 2'b00, 8'h00, 0, 1, 0, ed, 0, "rd");
  endfunction

  function automatic vec_t wr(bit s, int a, logic [1:0] ln,
                              logic [7:0] d, logic [7:0] ed);
    return mk(s, 1, 1, a, ln, d, 0, 0, 0, ed, 0, "wr");
  endfunction

  function automatic vec_t sw(bit s, logic [7:0] ed, bit eb);
    return mk(s, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, ed, eb, "sweep");
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    logic [7:0] dout;
    logic vld, er, bsy;
    @(negedge CLK);
    bus8.CS      = !v.s && v.cs;
    bus8.ZERO    = !v.s && v.z;
    bus6.CS      = v.s && v.cs;
    bus6.ZERO    = v.s && v.z;
    bus8.R_W     = v.rw;   bus6.R_W     = v.rw;
    bus8.ADDR    = v.a;    bus6.ADDR    = v.a;
    bus8.LANE_EN = v.ln;   bus6.LANE_EN = v.ln;
    bus8.DATA_IN = v.d;    bus6.DATA_IN = v.d;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    if (e.s) begin
      dout = bus6.DATA_OUT; vld = bus6.RD_VALID;
      er = bus6.ADDR_ERR;   bsy = bus6.BUSY;
    end else begin
      dout = bus8.DATA_OUT; vld = bus8.RD_VALID;
      er = bus8.ADDR_ERR;   bsy = bus8.BUSY;
    end
    chk({e.nm, ".DATA_OUT"}, dout, e.ed);
    chk({e.nm, ".RD_VALID"}, 8'(vld), 8'(e.ev));
    chk({e.nm, ".ADDR_ERR"}, 8'(er), 8'(e.ee));
    chk({e.nm, ".BUSY"}, 8'(bsy), 8'(e.eb));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.CS = 0; bus8.R_W = 0; bus8.ADDR = 0; bus8.LANE_EN = 0;
    bus8.DATA_IN = 0; bus8.ZERO = 0;
    bus6.CS = 0; bus6.R_W = 0; bus6.ADDR = 0; bus6.LANE_EN = 0;
    bus6.DATA_IN = 0; bus6.ZERO = 0;

    // DEPTH=8: reset contents, lanes, hold, CS=0
    for (int a = 0; a < 8; a++) tbl.push_back(rd(0, a, 8'h00));
    tbl.push_back(wr(0, 3, 2'b11, 8'hA5, 8'h00));
    tbl.push_back(wr(0, 3, 2'b01, 8'h3C, 8'h00));
    tbl.push_back(rd(0, 3, 8'hAC));
    tbl.push_back(mk(0, 1, 0, 3, 2'b00, 8'hFF, 0, 1, 0, 8'hAC, 0, "rd_noln"));
    tbl.push_back(wr(0, 5, 2'b00, 8'hFF, 8'hAC));
    tbl.push_back(rd(0, 5, 8'h00));
    tbl.push_back(wr(0, 6, 2'b10, 8'h5A, 8'h00));
    tbl.push_back(rd(0, 6, 8'h50));
    tbl.push_back(mk(0, 0, 1, 0, 2'b11, 8'hFF, 0, 0, 0, 8'h50, 0, "cs_off"));
    tbl.push_back(rd(0, 0, 8'h00));

    // zero-fill: 8 busy cycles, mid-sweep read/write/ZERO ignored
    for (int a = 0; a < 8; a++)
      tbl.push_back(wr(0, a, 2'b11, 8'((a + 1) * 17), 8'h00));
    tbl.push_back(rd(0, 7, 8'h88));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 8'h00, 1, 0, 0, 8'h88, 1, "zero"));
    tbl.push_back(sw(0, 8'h88, 1));
    tbl.push_back(mk(0, 1, 0, 2, 2'b00, 8'h00, 0, 0, 0, 8'h88, 1, "rd_mid"));
    tbl.push_back(mk(0, 1, 1, 4, 2'b11, 8'hFF, 1, 0, 0, 8'h88, 1, "z_mid"));
    for (int i = 0; i < 4; i++) tbl.push_back(sw(0, 8'h88, 1));
    tbl.push_back(sw(0, 8'h88, 0));
    for (int a = 0; a < 8; a++) tbl.push_back(rd(0, a, 8'h00));

    // ZERO beats a same-cycle write
    tbl.push_back(wr(0, 1, 2'b11, 8'h77, 8'h00));
    tbl.push_back(rd(0, 1, 8'h77));
    tbl.push_back(mk(0, 1, 1, 1, 2'b11, 8'h99, 1, 0, 0, 8'h77, 1, "z_prio"));
    for (int i = 0; i < 7; i++) tbl.push_back(sw(0, 8'h77, 1));
    tbl.push_back(sw(0, 8'h77, 0));
    tbl.push_back(rd(0, 1, 8'h00));

    // DEPTH=6: out of range and a non-power-of-two sweep
    tbl.push_back(wr(1, 2, 2'b11, 8'h42, 8'h00));
    tbl.push_back(rd(1, 2, 8'h42));
    tbl.push_back(mk(1, 1, 0, 6, 2'b00, 8'h00, 0, 0, 1, 8'h42, 0, "rd_oor"));
    tbl.push_back(mk(1, 1, 1, 7, 2'b11, 8'hFF, 0, 0, 1, 8'h42, 0, "wr_oor7"));
    tbl.push_back(mk(1, 1, 1, 6, 2'b11, 8'hFF, 0, 0, 1, 8'h42, 0, "wr_oor6"));
    for (int a = 0; a < 6; a++)
      tbl.push_back(rd(1, a, (a == 2) ? 8'h42 : 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 8'h00, 1, 0, 0, 8'h00, 1, "zero6"));
    for (int i = 0; i < 5; i++) tbl.push_back(sw(1, 8'h00, 1));
    tbl.push_back(sw(1, 8'h00, 0));
    tbl.push_back(rd(1, 2, 8'h00));

    repeat (2) @(negedge CLK);
    CLR = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // asynchronous CLR during the third sweep cycle
    step(wr(0, 7, 2'b11, 8'h55, 8'h00));
    step(rd(0, 7, 8'h55));
    step(mk(0, 0, 0, 0, 2'b00, 8'h00, 1, 0, 0, 8'h55, 1, "zero_rst"));
    step(sw(0, 8'h55, 1));
    step(sw(0, 8'h55, 1));
    #2;
    CLR = 1'b1;
    #1;
    chk("clr.BUSY", 8'(bus8.BUSY), 8'h00);
    chk("clr.DATA_OUT", bus8.DATA_OUT, 8'h00);
    chk("clr.RD_VALID", 8'(bus8.RD_VALID), 8'h00);
    @(negedge CLK);
    CLR = 1'b0;
    step(rd(0, 7, 8'h00));
    step(sw(0, 8'h00, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/ram_banked_nxm.md
Name: ram_banked_nxm

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 1-word/2-nibble RAM used in the ARQ1 datapath labs.
- Generalises to DEPTH words of DATA_W bits, split into LANE_W-bit lanes with per-lane write enables.
- Adds chip select, registered read with a valid strobe, out-of-range address detection, and a sequential zero-fill (sweep) engine with a BUSY flag.
- Sits between the lab CPU datapath and its register/memory bus.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of LANE_W.
- LANE_W, 4, lane (write-enable granule) width in bits.
- DEPTH, 8, number of words; need not be a power of two.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH.
- Derived localparam LANES = DATA_W/LANE_W (default 2).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- CLR  input  1  asynchronous, active-high reset.
- CS  input  1  chip select; access happens only when 1.
- R_W  input  1  1 = write, 0 = read.
- ADDR  input  ADDR_W  word address.
- LANE_EN  input  LANES  per-lane write enable; bit i covers DATA_IN[i*LANE_W +: LANE_W].
- DATA_IN  input  DATA_W  write data.
- ZERO  input  1  start zero-fill sweep; level-sampled.
- DATA_OUT  output  DATA_W  registered read data.
- RD_VALID  output  1  1-cycle strobe: DATA_OUT updated this cycle.
- ADDR_ERR  output  1  1-cycle strobe: access attempted with ADDR >= DEPTH.
- BUSY  output  1  sweep in progress.

Behaviour:
- Reset: CLR=1 asynchronously forces the following, and holds them while CLR=1:
  - every memory word to 0;
  - DATA_OUT=0, RD_VALID=0, ADDR_ERR=0, BUSY=0;
  - FSM to IDLE, sweep counter to 0.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when ZERO=1 at a rising edge.
  - SWEEP -> IDLE after the edge that writes word DEPTH-1.
- ZERO priority in IDLE: ZERO has priority over a same-cycle access. That access is dropped, with no write, no RD_VALID and no ADDR_ERR.
- SWEEP operation:
  - Writes 0 to word cnt each cycle, cnt = 0..DEPTH-1; BUSY=1 for exactly DEPTH cycles, starting the cycle after ZERO is sampled.
  - CS accesses are ignored: no write, no RD_VALID, no ADDR_ERR.
  - ZERO=1 is ignored; the sweep does not restart.
- Write (IDLE, CS=1, R_W=1, ADDR<DEPTH):
  - At the rising edge, each lane with LANE_EN[i]=1 takes its DATA_IN slice; other lanes hold.
  - LANE_EN=0 is a legal no-op.
  - DATA_OUT is unchanged.
- Read (IDLE, CS=1, R_W=0, ADDR<DEPTH):
  - At the rising edge, DATA_OUT <= mem[ADDR] and RD_VALID=1 for one cycle. Latency is 1 clock.
  - LANE_EN is ignored on reads.
- Holding DATA_OUT: DATA_OUT holds its last value whenever no valid read occurs. It is never driven X.
- Out of range (IDLE, CS=1, ADDR>=DEPTH): no memory or DATA_OUT change; ADDR_ERR=1 for one cycle; RD_VALID=0.
- CS=0: no state change except the FSM/sweep.
- Read-after-write: a read one cycle after a write to the same address returns the new data.
- Back-to-back reads: RD_VALID stays high on consecutive cycles.
- CLR mid-sweep: the sweep aborts and the state is as at reset; BUSY drops immediately, asynchronously.

Test Plan:
- Reset state: CLR pulse, then read addresses 0..7 -> DATA_OUT=0x00 and RD_VALID=1 on each of the 8 consecutive cycles.
- Lane enables: write 0xA5 to addr 3 with LANE_EN=11; write 0x3C to addr 3 with LANE_EN=01; read addr 3 -> DATA_OUT=0xAC one cycle after the read is presented.
- Out of range: DEPTH=6, ADDR_W=3; read addr 6 -> ADDR_ERR=1 for one cycle, RD_VALID=0, DATA_OUT keeps its previous value. Write 0xFF to addr 7 -> memory unchanged, verified by reading addrs 0..5.
- Zero-fill: fill words 0..7 with 0x11..0x88, pulse ZERO. Check:
  - BUSY=1 for exactly 8 cycles;
  - a read of addr 2 issued mid-sweep gives no RD_VALID;
  - after BUSY falls, all reads return 0x00.
- Reset mid-sweep: write 0x55 to addr 7, start sweep, assert CLR asynchronously at cycle 3 -> BUSY=0 immediately; a subsequent read of addr 7 returns 0x00.
- ZERO priority: assert ZERO together with a write of 0x99 to addr 1 -> write dropped, sweep runs; after the sweep, addr 1 reads 0x00.
